// File: rtl/battleship_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : battleship_pkg                                              |
// | Description: Shared board geometry, PC shot engine state encoding and    |
// |              cell-index to row/column conversion helpers.                |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package battleship_pkg;

  localparam int BOARD_DIM = 5;
  localparam int CELLS     = BOARD_DIM * BOARD_DIM;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } shot_state_e;

  // Row of a cell index (idx / BOARD_DIM), built from compares so no divider
  // is inferred.
  function automatic logic [2:0] idx_to_row(input logic [4:0] idx);
    logic [2:0] row;
    row = 3'd0;
    for (int r = 1; r < BOARD_DIM; r++) begin
      if (idx >= 5'(r * BOARD_DIM)) row = 3'(r);
    end
    return row;
  endfunction

  // Column of a cell index (idx % BOARD_DIM).
  function automatic logic [2:0] idx_to_col(input logic [4:0] idx);
    logic [4:0] base;
    base = 5'(idx_to_row(idx)) * 5'(BOARD_DIM);
    return 3'(idx - base);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr5.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : lfsr5                                                       |
// | Description: Free-running 5-bit Fibonacci LFSR, polynomial x^5+x^3+1,    |
// |              maximal length (31 states, never zero for a nonzero seed).  |
// | Ports      : clk   - clock                                               |
// |              rst   - asynchronous active-high reset (loads SEED)         |
// |              value - current LFSR state                                  |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module lfsr5 #(
  parameter logic [4:0] SEED = 5'b00001
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] value
);

  logic [4:0] lfsr_q;
  logic [4:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/pc_shot_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : pc_shot_engine                                              |
// | Description: Picks a random not-yet-fired cell for the PC player, reports|
// |              hit/miss against the player's ship map and flags the win.   |
// | Ports      : clk, rst     - clock, asynchronous active-high reset        |
// |              clear        - synchronous new-game clear                   |
// |              turno_pc     - request one PC shot                          |
// |              ship_map     - player ship occupancy, bit i = cell i        |
// |              shot_valid   - one-cycle pulse, shot fields valid           |
// |              shot_row/col - coordinates of the last shot                 |
// |              shot_hit     - last shot struck a ship                      |
// |              pc_win       - every ship cell has been hit (sticky)        |
// |              busy         - shot in progress                             |
// |              no_shot      - request refused, board fully fired           |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module pc_shot_engine
  import battleship_pkg::*;
#(
  parameter int         BOARD_DIM = 5,
  parameter logic [4:0] LFSR_SEED = 5'b00001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             turno_pc,
  input  logic [CELLS-1:0] ship_map,
  output logic             shot_valid,
  output logic [2:0]       shot_row,
  output logic [2:0]       shot_col,
  output logic             shot_hit,
  output logic             pc_win,
  output logic             busy,
  output logic             no_shot
);

  localparam int NCELLS = BOARD_DIM * BOARD_DIM;

  shot_state_e      state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [CELLS-1:0] fired_q, fired_d;
  logic [CELLS-1:0] hits_q, hits_d;
  logic             shot_valid_q, shot_valid_d;
  logic [2:0]       shot_row_q, shot_row_d;
  logic [2:0]       shot_col_q, shot_col_d;
  logic             shot_hit_q, shot_hit_d;
  logic             pc_win_q, pc_win_d;
  logic             busy_q, busy_d;
  logic             no_shot_q, no_shot_d;

  logic [4:0]       lfsr_val;
  logic [4:0]       cand;
  logic             cand_ok;
  logic [31:0]      fired_ext;
  logic [CELLS-1:0] idx_onehot;
  logic [CELLS-1:0] hits_next;

  lfsr5 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_val)
  );

  always_comb begin
    // LFSR runs 1..31, so lfsr-1 covers 0..30; values 25..30 are off-board
    // and simply cost one more search cycle.
    cand       = lfsr_val - 5'd1;
    // Zero-extended copy lets off-board candidates index safely.
    fired_ext  = {{(32 - CELLS){1'b0}}, fired_q};
    cand_ok    = (cand < 5'(NCELLS)) && !fired_ext[cand];
    idx_onehot = {{(CELLS - 1){1'b0}}, 1'b1} << idx_q;
    hits_next  = hits_q | (ship_map[idx_q] ? idx_onehot : '0);

    state_d      = state_q;
    idx_d        = idx_q;
    fired_d      = fired_q;
    hits_d       = hits_q;
    shot_valid_d = 1'b0;
    shot_row_d   = shot_row_q;
    shot_col_d   = shot_col_q;
    shot_hit_d   = shot_hit_q;
    pc_win_d     = pc_win_q;
    no_shot_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (turno_pc) begin
          if (fired_q == '1) no_shot_d = 1'b1;
          else               state_d   = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        // Shot fields are loaded on entry to COMMIT so they are registered
        // and valid for the whole COMMIT cycle.
        if (cand_ok) begin
          idx_d        = cand;
          state_d      = ST_COMMIT;
          shot_valid_d = 1'b1;
          shot_row_d   = idx_to_row(cand);
          shot_col_d   = idx_to_col(cand);
          shot_hit_d   = ship_map[cand];
        end
      end
      ST_COMMIT: begin
        fired_d = fired_q | idx_onehot;
        hits_d  = hits_next;
        if ((ship_map != '0) && ((hits_next & ship_map) == ship_map)) begin
          pc_win_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // New-game clear overrides everything above, including a shot request.
    if (clear) begin
      state_d      = ST_IDLE;
      fired_d      = '0;
      hits_d       = '0;
      pc_win_d     = 1'b0;
      shot_hit_d   = 1'b0;
      shot_valid_d = 1'b0;
      no_shot_d    = 1'b0;
    end

    busy_d = (state_d == ST_SEARCH) || (state_d == ST_COMMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 5'd0;
      fired_q      <= '0;
      hits_q       <= '0;
      shot_valid_q <= 1'b0;
      shot_row_q   <= 3'd0;
      shot_col_q   <= 3'd0;
      shot_hit_q   <= 1'b0;
      pc_win_q     <= 1'b0;
      busy_q       <= 1'b0;
      no_shot_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fired_q      <= fired_d;
      hits_q       <= hits_d;
      shot_valid_q <= shot_valid_d;
      shot_row_q   <= shot_row_d;
      shot_col_q   <= shot_col_d;
      shot_hit_q   <= shot_hit_d;
      pc_win_q     <= pc_win_d;
      busy_q       <= busy_d;
      no_shot_q    <= no_shot_d;
    end
  end

  assign shot_valid = shot_valid_q;
  assign shot_row   = shot_row_q;
  assign shot_col   = shot_col_q;
  assign shot_hit   = shot_hit_q;
  assign pc_win     = pc_win_q;
  assign busy       = busy_q;
  assign no_shot    = no_shot_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_shot_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_pc_shot_engine                                           |
// | Description: Directed self-checking bench for pc_shot_engine.            |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pc_shot_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        turno_pc;
  logic [24:0] ship_map;
  logic        shot_valid;
  logic [2:0]  shot_row;
  logic [2:0]  shot_col;
  logic        shot_hit;
  logic        pc_win;
  logic        busy;
  logic        no_shot;

  int          passed = 0;
  int          total  = 0;
  int          lat;
  int          pos;
  int          pulses;
  int          rises;
  logic        prev_busy;
  logic        any_v;
  logic        any_b;
  logic [24:0] seen;

  pc_shot_engine #(
    .BOARD_DIM (5),
    .LFSR_SEED (5'b00001)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .turno_pc   (turno_pc),
    .ship_map   (ship_map),
    .shot_valid (shot_valid),
    .shot_row   (shot_row),
    .shot_col   (shot_col),
    .shot_hit   (shot_hit),
    .pc_win     (pc_win),
    .busy       (busy),
    .no_shot    (no_shot)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One-cycle request; lat counts clock edges from the sampling edge to the
  // edge after which shot_valid is seen (2 = fastest possible).
  task automatic request(output int l);
    turno_pc = 1'b1;
    step();
    turno_pc = 1'b0;
    l = 1;
    while (shot_valid !== 1'b1 && l < 40) begin
      step();
      l = l + 1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, shot_valid, 0);
    check({tag, "_row"},   shot_row,   0);
    check({tag, "_col"},   shot_col,   0);
    check({tag, "_hit"},   shot_hit,   0);
    check({tag, "_win"},   pc_win,     0);
    check({tag, "_busy"},  busy,       0);
    check({tag, "_noshot"}, no_shot,   0);
  endtask

  initial begin
    rst      = 1'b1;
    clear    = 1'b0;
    turno_pc = 1'b0;
    ship_map = 25'h0;
    step();
    step();
    check_all_zero("reset");

    // First shot after reset, empty ship map: lfsr 1->2 gives cell 1.
    rst      = 1'b0;
    turno_pc = 1'b1;
    step();
    turno_pc = 1'b0;
    check("t1_busy_search", busy, 1);
    check("t1_valid_early", shot_valid, 0);
    step();
    check("t1_valid", shot_valid, 1);
    check("t1_row", shot_row, 0);
    check("t1_col", shot_col, 1);
    check("t1_hit", shot_hit, 0);
    check("t1_busy_commit", busy, 1);
    step();
    check("t1_valid_pulse", shot_valid, 0);
    check("t1_busy_idle", busy, 0);
    check("t1_win", pc_win, 0);

    // Single ship on cell 1: the same first shot sinks it and wins.
    rst = 1'b1;
    step();
    ship_map = 25'h0000002;
    rst      = 1'b0;
    turno_pc = 1'b1;
    step();
    turno_pc = 1'b0;
    step();
    check("t2_valid", shot_valid, 1);
    check("t2_hit", shot_hit, 1);
    check("t2_col", shot_col, 1);
    check("t2_win_early", pc_win, 0);
    step();
    check("t2_win", pc_win, 1);
    check("t2_busy", busy, 0);
    any_v    = 1'b0;
    any_b    = 1'b0;
    turno_pc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      any_v = any_v | shot_valid;
      any_b = any_b | busy;
    end
    turno_pc = 1'b0;
    check("t2_done_no_valid", any_v, 0);
    check("t2_done_no_busy", any_b, 0);
    check("t2_win_held", pc_win, 1);
    check("t2_hit_held", shot_hit, 1);

    // Clear in DONE, asserted together with a request: clear wins.
    clear    = 1'b1;
    turno_pc = 1'b1;
    step();
    clear    = 1'b0;
    turno_pc = 1'b0;
    check("t3_clear_win", pc_win, 0);
    check("t3_clear_hit", shot_hit, 0);
    check("t3_clear_busy", busy, 0);
    ship_map = 25'h0;
    request(lat);
    check("t3_valid", shot_valid, 1);
    check("t3_lat", (lat >= 2 && lat <= 32), 1);
    step();
    check("t3_idle", busy, 0);

    // turno_pc held high: one shot per busy episode.
    pulses    = 0;
    rises     = 0;
    prev_busy = 1'b0;
    turno_pc  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (shot_valid) pulses = pulses + 1;
      if (busy && !prev_busy) rises = rises + 1;
      prev_busy = busy;
    end
    turno_pc = 1'b0;
    for (int i = 0; i < 40 && busy; i++) begin
      step();
      if (shot_valid) pulses = pulses + 1;
      if (busy && !prev_busy) rises = rises + 1;
      prev_busy = busy;
    end
    check("t4_settled", busy, 0);
    check("t4_some_shots", (pulses >= 1), 1);
    check("t4_one_per_entry", pulses, rises);

    // Fill the whole board: 25 distinct cells, then a refused request.
    clear = 1'b1;
    step();
    clear = 1'b0;
    seen  = 25'h0;
    for (int n = 0; n < 25; n++) begin
      request(lat);
      check("t5_valid", shot_valid, 1);
      check("t5_lat", (lat >= 2 && lat <= 32), 1);
      check("t5_range", (shot_row < 3'd5 && shot_col < 3'd5), 1);
      pos = int'(shot_row) * 5 + int'(shot_col);
      if (pos > 24) pos = 0;
      check("t5_distinct", seen[pos], 0);
      seen[pos] = 1'b1;
      step();
    end
    check("t5_all_cells", seen, 25'h1FFFFFF);
    turno_pc = 1'b1;
    step();
    turno_pc = 1'b0;
    check("t5_no_shot", no_shot, 1);
    check("t5_no_busy", busy, 0);
    check("t5_no_valid", shot_valid, 0);
    step();
    check("t5_no_shot_pulse", no_shot, 0);
    any_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      any_v = any_v | shot_valid | busy;
    end
    check("t5_quiet", any_v, 0);

    // Reset during SEARCH aborts the shot.
    clear = 1'b1;
    step();
    clear    = 1'b0;
    turno_pc = 1'b1;
    step();
    turno_pc = 1'b0;
    check("t6_busy", busy, 1);
    rst = 1'b1;
    #2;
    check_all_zero("t6_async");
    any_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      any_v = any_v | shot_valid;
    end
    check("t6_no_valid", any_v, 0);
    rst = 1'b0;
    step();
    check_all_zero("t6_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pc_shot_engine.md
PC_SHOT_ENGINE -- requirements
Module: pc_shot_engine

Interface
REQ-001 Parameter BOARD_DIM, 5, board side length; CELLS = BOARD_DIM*BOARD_DIM = 25; only 5 is supported.
REQ-002 Parameter LFSR_SEED, 5'b00001, LFSR reset value; SHALL be nonzero.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clear  input  1  synchronous new-game clear of shot history, hit map and win flag.
REQ-006 turno_pc  input  1  start request for one PC shot (game controller PC-turn strobe).
REQ-007 ship_map  input  25  player ship occupancy, bit i = cell i; must be stable while busy.
REQ-008 shot_valid  output  1  one-cycle pulse; shot fields valid this cycle (controller V).
REQ-009 shot_row  output  3  row of last shot, idx/5.
REQ-010 shot_col  output  3  column of last shot, idx%5.
REQ-011 shot_hit  output  1  last shot struck a ship cell; held until next shot.
REQ-012 pc_win  output  1  all ship cells hit (controller VP); level, sticky until clear/rst.
REQ-013 busy  output  1  high in SEARCH and COMMIT.
REQ-014 no_shot  output  1  one-cycle pulse; request refused because all 25 cells already fired.

Function
REQ-015 5-bit Fibonacci LFSR, x^5+x^3+1, next = {lfsr[3:0], lfsr[4]^lfsr[2]}, advances every clock in every state; never zero.
REQ-016 States: IDLE, SEARCH, COMMIT, DONE.
REQ-017 IDLE: turno_pc=1 with fired != all-ones -> SEARCH; with fired == all-ones -> stay IDLE, pulse no_shot next cycle.
REQ-018 SEARCH: candidate idx = lfsr-1; if idx<25 and fired[idx]=0 -> latch idx, go COMMIT; else stay SEARCH.
REQ-019 Free cell SHALL be found within 31 SEARCH cycles (full LFSR period).
REQ-020 COMMIT (one cycle): shot_valid=1, shot_row/shot_col from latched idx, shot_hit=ship_map[idx]; at exit edge set fired[idx], set hits[idx] if ship_map[idx].
REQ-021 At COMMIT exit: if ship_map!=0 and (hits_next & ship_map)==ship_map -> pc_win=1, state DONE; else IDLE.
REQ-022 Latency: turno_pc sampled -> shot_valid high minimum 2 cycles, maximum 32 cycles.
REQ-023 turno_pc while busy or in DONE: ignored, no queuing.
REQ-024 DONE: holds pc_win=1, all requests ignored until clear.
REQ-025 clear (any state): fired=0, hits=0, pc_win=0, shot_hit=0, state IDLE next cycle; LFSR unaffected; clear has priority over turno_pc.
REQ-026 ship_map=0: shots proceed normally, shot_hit=0, pc_win never set.

Reset
REQ-027 rst: state IDLE, lfsr=LFSR_SEED, fired=0, hits=0, idx=0.
REQ-028 rst: shot_valid=0, shot_row=0, shot_col=0, shot_hit=0, pc_win=0, busy=0, no_shot=0.
REQ-029 rst mid-SEARCH/COMMIT: shot aborted, no shot_valid pulse, history not updated.

Structure
REQ-030 battleship_pkg: BOARD_DIM, CELLS, state enum, idx-to-row/col conversion function.
REQ-031 Sub-module lfsr5 (clk, rst, seed parameter, 5-bit output); all else in pc_shot_engine.
REQ-032 All outputs registered.

Verification
REQ-033 Reset release, turno_pc=1 first cycle (lfsr=1), ship_map=0 -> 2 cycles later shot_valid=1, row 0, col 1, shot_hit=0.
REQ-034 ship_map with single bit 1 set, same stimulus -> shot_valid with shot_hit=1, pc_win=1 next cycle, state DONE; further turno_pc gives no shot_valid.
REQ-035 25 consecutive requests, ship_map=0 -> 25 distinct (row,col), each latency <=32; 26th -> no_shot pulse, no shot_valid.
REQ-036 turno_pc held high 10 cycles -> exactly one shot_valid per IDLE entry, none while busy.
REQ-037 clear in DONE -> pc_win=0 next cycle, next request yields valid shot; rst asserted mid-SEARCH -> no shot_valid, all outputs 0.
